// File: rtl/sub_serial_if.sv
// Start/done handshake and operand/result bundle for sub_serial.
// The master drives operands and start; the slave returns result and flags.
interface sub_serial_if;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] C;
  logic       borrow;
  logic       zero;

  modport master (
    output start, A, B,
    input  ready, busy, done, C, borrow, zero
  );

  modport slave (
    input  start, A, B,
    output ready, busy, done, C, borrow, zero
  );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial 8-bit subtractor C = A - B, LSB first, 10 cycles per op.
// Optional SUB_SATURATE_EN clamps an underflowing result to 0x00.
module sub_serial (
  input  logic         clk,
  input  logic         rst_n,
  sub_serial_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic [7:0] res_q, res_d;
  logic [7:0] c_q, c_d;
  logic       borrow_q, borrow_d;
  logic       zero_q, zero_d;

  logic sum;
  logic cout;

  assign sum  = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign cout = (opa_q[0] & opb_q[0])
              | (opa_q[0] & carry_q)
              | (opb_q[0] & carry_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    c_d      = c_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.A;
          opb_d   = ~bus.B;
          carry_d = 1'b1;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d   = {sum, res_q[7:1]};
        opa_d   = {1'b0, opa_q[7:1]};
        opb_d   = {1'b0, opb_q[7:1]};
        carry_d = cout;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d  = DONE;
          c_d      = res_d;
          borrow_d = ~cout;
          zero_d   = (res_d == 8'h00);
`ifdef SUB_SATURATE_EN
          // Unsigned floor at zero on underflow.
          if (!cout) begin
            c_d    = 8'h00;
            zero_d = 1'b1;
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      carry_q  <= 1'b1;
      opa_q    <= 8'h00;
      opb_q    <= 8'h00;
      res_q    <= 8'h00;
      c_q      <= 8'h00;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      c_q      <= c_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.busy   = (state_q == SHIFT) || (state_q == DONE);
  assign bus.done   = (state_q == DONE);
  assign bus.C      = c_q;
  assign bus.borrow = borrow_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial against an arithmetic reference.
// Handshake timing, flags, back-to-back issue and mid-op reset.
module tb_sub_serial;
  logic clk;
  logic rst_n;
  int   tests;
  int   failures;

  sub_serial_if bus ();

  sub_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
    int d;
    logic [7:0] c;
    logic bo;
    d  = int'(a) - int'(b);
    bo = (a < b);
    c  = d[7:0];
`ifdef SUB_SATURATE_EN
    if (bo) c = 8'h00;
`endif
    return {bo, (c == 8'h00), c};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.A = 8'h00;
    bus.B = 8'h00;
    #1;
    tests++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_hs got=%b want=100", {bus.ready, bus.busy, bus.done});
    end
    tests++;
    if ({bus.C, bus.borrow, bus.zero} !== 10'h000) begin
      failures++;
      $display("FAIL reset_out got C=%h b=%b z=%b want 00/0/0", bus.C, bus.borrow, bus.zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string nm);
    logic [9:0] exp;
    logic [7:0] c_prev;
    exp = model(a, b);
    @(negedge clk);
    c_prev = bus.C;
    tests++;
    if (bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_pre got=%b want=1", nm, bus.ready);
    end
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    tests++;
    if ({bus.ready, bus.busy} !== 2'b01) begin
      failures++;
      $display("FAIL %s accept got r/b=%b want=01", nm, {bus.ready, bus.busy});
    end
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.A = 8'($urandom);
      bus.B = 8'($urandom);
      @(posedge clk);
      #1;
      if (n < 8) begin
        tests++;
        if ({bus.done, bus.ready, bus.C} !== {2'b00, c_prev}) begin
          failures++;
          $display("FAIL %s mid%0d got d=%b r=%b C=%h want 0/0/%h",
                   nm, n, bus.done, bus.ready, bus.C, c_prev);
        end
      end else if (n == 8) begin
        tests++;
        if ({bus.done, bus.busy, bus.ready} !== 3'b110) begin
          failures++;
          $display("FAIL %s done_hs got=%b want=110", nm, {bus.done, bus.busy, bus.ready});
        end
        tests++;
        if ({bus.borrow, bus.zero, bus.C} !== exp) begin
          failures++;
          $display("FAIL %s result got b=%b z=%b C=%h want b=%b z=%b C=%h",
                   nm, bus.borrow, bus.zero, bus.C, exp[9], exp[8], exp[7:0]);
        end
      end else begin
        tests++;
        if ({bus.done, bus.busy, bus.ready, bus.C} !== {3'b001, exp[7:0]}) begin
          failures++;
          $display("FAIL %s idle got d/b/r=%b C=%h want 001 C=%h",
                   nm, {bus.done, bus.busy, bus.ready}, bus.C, exp[7:0]);
        end
      end
    end
  endtask

  task automatic test_directed();
    run_op(8'h05, 8'h03, "basic");
    run_op(8'h03, 8'h05, "underflow");
    run_op(8'h80, 8'h80, "equal");
    run_op(8'h00, 8'hFF, "ext_lo");
    run_op(8'hFF, 8'h00, "ext_hi");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom), 8'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ha [0:29];
    logic [7:0] hb [0:29];
    logic [9:0] exp;
    logic [7:0] c_hold;
    @(negedge clk);
    c_hold = bus.C;
    for (int n = 0; n < 30; n++) begin
      ha[n] = 8'($urandom);
      hb[n] = 8'($urandom);
      bus.start = 1'b1;
      bus.A = ha[n];
      bus.B = hb[n];
      @(posedge clk);
      #1;
      if (n % 10 == 0) begin
        tests++;
        if ({bus.ready, bus.busy} !== 2'b01) begin
          failures++;
          $display("FAIL b2b_accept n=%0d got r/b=%b want=01", n, {bus.ready, bus.busy});
        end
      end
      if (n % 10 == 8) begin
        exp = model(ha[n-8], hb[n-8]);
        c_hold = exp[7:0];
        tests++;
        if ({bus.done, bus.borrow, bus.zero, bus.C} !== {1'b1, exp}) begin
          failures++;
          $display("FAIL b2b_result n=%0d got d=%b b=%b z=%b C=%h want 1/%b/%b/%h",
                   n, bus.done, bus.borrow, bus.zero, bus.C, exp[9], exp[8], exp[7:0]);
        end
      end else begin
        tests++;
        if ({bus.done, bus.C} !== {1'b0, c_hold}) begin
          failures++;
          $display("FAIL b2b_hold n=%0d got d=%b C=%h want 0/%h", n, bus.done, bus.C, c_hold);
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'h10;
    bus.B = 8'h01;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.C, bus.busy, bus.ready, bus.done} !== {8'h00, 3'b010}) begin
      failures++;
      $display("FAIL rst_mid got C=%h b/r/d=%b want 00 010",
               bus.C, {bus.busy, bus.ready, bus.done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({bus.done, bus.C} !== 9'h000) begin
        failures++;
        $display("FAIL rst_nodone n=%0d got d=%b C=%h want 0/00", n, bus.done, bus.C);
      end
    end
    run_op(8'h10, 8'h01, "after_rst");
  endtask

  initial begin
    tests = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/sub_serial.md
# sub_serial

Bit-serial 8-bit subtractor computing C = A − B over eight clock cycles with a start/done handshake. It is the subtract-direction companion to the datapath's combinational 8-bit adder. The ALU sequencer uses it where area matters more than latency. It runs two's-complement addition (A + ~B + 1) one bit per cycle, LSB first, and reports borrow and zero flags.

## Interface
Parameters: none (width fixed at 8).
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- A  input  8  minuend, latched on accepted start
- B  input  8  subtrahend, latched on accepted start
- ready  output  1  high in IDLE; start accepted
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; C/borrow/zero just updated
- C  output  8  registered result; holds until next completion
- borrow  output  1  registered; 1 when A < B (unsigned)
- zero  output  1  registered; 1 when C == 0x00

## Operation
- Reset (async, rst_n=0): state=IDLE, C=0x00, borrow=0, zero=0, done=0, busy=0, ready=1, bit counter=0, internal carry=1.
- States:
  - IDLE: ready=1. On an edge with start=1, latch A→opA and B→~B→opB, set carry=1, clear counter, go to SHIFT.
  - SHIFT: each edge processes bit 0 of opA/opB:
    - sum = a0 ^ b0 ^ carry
    - carry' = majority(a0, b0, carry)
    - sum shifts into the result register from the MSB; opA and opB shift right.
    - After the 8th bit (counter=7), go to DONE and load the output registers:
      - C = result
      - borrow = ~carry_out
      - zero = (C==0)
  - DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start in SHIFT or DONE is ignored. It is not queued.
- A and B may change freely after acceptance. Only the latched copies are used.
- Arithmetic is mod 256. Unsigned borrow only; no signed overflow flag.
- C, borrow and zero change only on DONE entry or reset. They hold their values indefinitely otherwise.

## Timing
- Start accepted at edge k: busy=1 and ready=0 from edge k.
- Bit i is processed at edge k+1+i, i=0..7.
- Outputs update and done rises at edge k+8. done falls at edge k+9, when the block returns to IDLE.
- The earliest next start is accepted at edge k+10. Throughput is one operation per 10 cycles.
- Reset mid-operation aborts at once: no done pulse, previous results cleared to reset values.
- start held high continuously gives back-to-back operations every 10 cycles, with operands sampled at each acceptance edge.

## Configuration
- SUB_SATURATE_EN defined: when the result borrows, C=0x00, zero=1 and borrow=1 (unsigned floor at zero).
- SUB_SATURATE_EN undefined: C = (A − B) mod 256, zero reflects that value, and borrow flags the underflow.
- Latency and handshake are identical in both builds.

## Test plan
- Basic subtraction: A=0x05, B=0x03, start pulse at edge k → done only at edge k+8, C=0x02, borrow=0, zero=0. ready=0 during k..k+9.
- Underflow: A=0x03, B=0x05 → C=0xFE, borrow=1, zero=0. With SUB_SATURATE_EN: C=0x00, borrow=1, zero=1.
- Equal operands: A=0x80, B=0x80 → C=0x00, zero=1, borrow=0.
- Extremes: A=0x00, B=0xFF → C=0x01, borrow=1. A=0xFF, B=0x00 → C=0xFF, borrow=0.
- Operand stability and back-to-back issue:
  - Hold start=1 and change A/B every cycle during the operation. The result must reflect only the operands at the acceptance edge.
  - The second operation must be accepted exactly at edge k+10.
  - The prior C must hold between done pulses.
- Reset mid-operation: drop rst_n during bit 4 of A=0x10, B=0x01 → immediately C=0x00, busy=0, ready=1, no done pulse. A following A=0x10, B=0x01 must then give C=0x0F.
